// File: rtl/ssd_pkg.sv
// Shared definitions for the multiplexed seven-segment display controller:
// register map offsets, CTRL/STATUS bit positions and the scan state type.
package ssd_pkg;

  localparam logic [31:0] DATA_OFS   = 32'h0000_0000;
  localparam logic [31:0] CTRL_OFS   = 32'h0000_0004;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0008;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_LZB_BIT   = 1;
  localparam int CTRL_MASK_LSB  = 8;
  localparam int STATUS_GAP_BIT = 8;

  typedef enum logic {
    LIT = 1'b0,
    GAP = 1'b1
  } scan_state_e;

  // Word-granular window decode; the byte-lane bits of the address are ignored.
  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] ofs);
    return addr[31:2] == (base[31:2] + ofs[31:2]);
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Hex nibble to seven-segment pattern, segments gfedcba with bit0 = a,
// active-high. One instance is shared by all scanned digits.
module ssd_hex_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'h00;
    case (nibble)
      4'h0: segments = 7'h3F;
      4'h1: segments = 7'h06;
      4'h2: segments = 7'h5B;
      4'h3: segments = 7'h4F;
      4'h4: segments = 7'h66;
      4'h5: segments = 7'h6D;
      4'h6: segments = 7'h7D;
      4'h7: segments = 7'h07;
      4'h8: segments = 7'h7F;
      4'h9: segments = 7'h6F;
      4'hA: segments = 7'h77;
      4'hB: segments = 7'h7C;
      4'hC: segments = 7'h39;
      4'hD: segments = 7'h5E;
      4'hE: segments = 7'h79;
      4'hF: segments = 7'h71;
      default: segments = 7'h00;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Memory-mapped N-digit multiplexed seven-segment controller with a one-cycle
// dead-time gap between digits, leading-zero blanking and per-digit masking.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int          NUM_DIGITS     = 4,
  parameter int          REFRESH_DIV    = 50000,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0100,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_write_enable,
  input  logic [31:0]           write_addr,
  input  logic [31:0]           write_data,
  input  logic [31:0]           read_addr,
  output logic [31:0]           read_data,
  output logic                  read_hit,
  output logic [6:0]            ssd_pins,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("ssd_scan_ctrl: NUM_DIGITS must be in 1..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("ssd_scan_ctrl: REFRESH_DIV must be at least 2");
  end

  logic [DW-1:0]         data_q;
  logic                  en_q, lzb_q;
  logic [NUM_DIGITS-1:0] mask_q;
  scan_state_e           state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [2:0]            idx_q, idx_d;

  logic wr_data, wr_ctrl;
  assign wr_data = mem_write_enable && addr_hit(write_addr, BASE_ADDR, DATA_OFS);
  assign wr_ctrl = mem_write_enable && addr_hit(write_addr, BASE_ADDR, CTRL_OFS);

  // Byte-lane address bits and unimplemented data bits are deliberately dropped.
  logic unused_bits;
  assign unused_bits = ^{write_addr[1:0], read_addr[1:0], write_data};

  // NOTE: every flop is updated with <= so all registers sample pre-edge values,
  // which is also what makes a same-cycle read return the pre-write contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      en_q   <= 1'b1;
      lzb_q  <= 1'b0;
      mask_q <= '0;
    end else begin
      if (wr_data) data_q <= write_data[DW-1:0];
      if (wr_ctrl) begin
        en_q   <= write_data[CTRL_EN_BIT];
        lzb_q  <= write_data[CTRL_LZB_BIT];
        mask_q <= write_data[CTRL_MASK_LSB +: NUM_DIGITS];
      end
    end
  end

  logic [31:0] data_word, ctrl_word, status_word, read_mux;
  logic        read_match;
  assign data_word = 32'(data_q);

  always_comb begin
    ctrl_word                                 = '0;
    ctrl_word[CTRL_EN_BIT]                    = en_q;
    ctrl_word[CTRL_LZB_BIT]                   = lzb_q;
    ctrl_word[CTRL_MASK_LSB +: NUM_DIGITS]    = mask_q;
    status_word                               = '0;
    status_word[2:0]                          = idx_q;
    status_word[STATUS_GAP_BIT]               = (state_q == GAP);
  end

  always_comb begin
    read_mux   = '0;
    read_match = 1'b1;
    if (addr_hit(read_addr, BASE_ADDR, DATA_OFS))        read_mux = data_word;
    else if (addr_hit(read_addr, BASE_ADDR, CTRL_OFS))   read_mux = ctrl_word;
    else if (addr_hit(read_addr, BASE_ADDR, STATUS_OFS)) read_mux = status_word;
    else                                                 read_match = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data <= '0;
      read_hit  <= 1'b0;
    end else begin
      read_data <= read_mux;
      read_hit  <= read_match;
    end
  end

  // NOTE: next-state signals get their hold values first so no path through
  // this block can leave them unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    if (en_q) begin
      case (state_q)
        LIT: begin
          if (presc_q == PW'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            state_d = GAP;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        GAP: begin
          idx_d   = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
          state_d = LIT;
        end
        default: state_d = LIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LIT;
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  logic [3:0]            nibble;
  logic [6:0]            seg_dec;
  logic [7:0]            mask_word;
  logic                  lzb_dark, dark;
  logic [NUM_DIGITS-1:0] onehot;

  assign nibble = data_word[{idx_q, 2'b00} +: 4];

  ssd_hex_decoder u_dec (
    .nibble   (nibble),
    .segments (seg_dec)
  );

  // Leading-zero: this digit and every digit above it are zero; digit 0 always shows.
  assign lzb_dark  = lzb_q && (idx_q != 3'd0) && ((data_word >> {idx_q, 2'b00}) == 32'd0);
  assign mask_word = 8'(mask_q);
  assign dark      = mask_word[idx_q] || lzb_dark;
  assign onehot    = NUM_DIGITS'(1) << idx_q;

  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] sel_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= '0;
      sel_q <= '0;
    end else if (en_q && (state_q == LIT) && !dark) begin
      seg_q <= seg_dec;
      sel_q <= onehot;
    end else begin
      seg_q <= '0;
      sel_q <= '0;
    end
  end

  assign ssd_pins  = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign digit_sel = sel_q ^ {NUM_DIGITS{SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl (4 digits, REFRESH_DIV=4): scan timing,
// register access, blanking, masking, enable hold and reset/polarity.
module tb_ssd_scan_ctrl;

  localparam int          ND     = 4;
  localparam int          RD     = 4;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_CTRL = BASE + 32'd4;
  localparam logic [31:0] A_STAT = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [31:0] waddr = '0, wdata = '0, raddr = '0;

  logic [31:0]   rd_data, n_rd_data;
  logic          rd_hit, n_rd_hit;
  logic [6:0]    pins, n_pins;
  logic [ND-1:0] sel, n_sel;

  ssd_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BASE_ADDR(BASE), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .mem_write_enable(we), .write_addr(waddr), .write_data(wdata),
    .read_addr(raddr), .read_data(rd_data), .read_hit(rd_hit), .ssd_pins(pins), .digit_sel(sel)
  );

  ssd_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BASE_ADDR(BASE), .SEG_ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .reset(reset), .mem_write_enable(we), .write_addr(waddr), .write_data(wdata),
    .read_addr(raddr), .read_data(n_rd_data), .read_hit(n_rd_hit), .ssd_pins(n_pins), .digit_sel(n_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] cycles;
    logic [3:0] sel;
    logic [6:0] seg;
  } scan_vec_t;

  typedef struct packed {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp_data;
    logic        exp_hit;
  } reg_vec_t;

  scan_vec_t scan_tbl[10];
  reg_vec_t  reg_tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
  endtask

  // Checks both the active-high instance and its inverted twin.
  task automatic chk_out(input string name, input logic [3:0] exp_sel, input logic [6:0] exp_seg);
    check(name, {21'd0, sel, pins}, {21'd0, exp_sel, exp_seg});
    check({name, "_inv"}, {21'd0, n_sel, n_pins}, {21'd0, ~exp_sel, ~exp_seg});
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    #20;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Watches the scan for a number of cycles: only digits in 'lit' may light,
  // each with its expected pattern, and every digit in 'lit' must appear.
  task automatic observe(input string name, input int cycles, input logic [3:0] lit,
                         input logic [27:0] segs);
    logic [3:0] seen;
    int         idx;
    seen = '0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (sel == 4'b0000) begin
        check($sformatf("%s dark seg c%0d", name, c), {25'd0, pins}, 32'd0);
      end else if ($onehot(sel) && ((sel & ~lit) == 4'b0000)) begin
        idx = 0;
        for (int b = 0; b < ND; b++) if (sel[b]) idx = b;
        seen |= sel;
        check($sformatf("%s d%0d seg c%0d", name, idx, c), {25'd0, pins}, {25'd0, segs[idx*7 +: 7]});
      end else begin
        check($sformatf("%s stray sel c%0d", name, c), {28'd0, sel}, 32'd0);
      end
    end
    check({name, " digits seen"}, {28'd0, seen}, {28'd0, lit});
  endtask

  initial begin
    scan_tbl[0] = '{8'd1, 4'b0001, 7'h3F};
    scan_tbl[1] = '{8'd3, 4'b0001, 7'h66};
    scan_tbl[2] = '{8'd1, 4'b0000, 7'h00};
    scan_tbl[3] = '{8'd4, 4'b0010, 7'h4F};
    scan_tbl[4] = '{8'd1, 4'b0000, 7'h00};
    scan_tbl[5] = '{8'd4, 4'b0100, 7'h5B};
    scan_tbl[6] = '{8'd1, 4'b0000, 7'h00};
    scan_tbl[7] = '{8'd4, 4'b1000, 7'h06};
    scan_tbl[8] = '{8'd1, 4'b0000, 7'h00};
    scan_tbl[9] = '{8'd2, 4'b0001, 7'h66};

    reg_tbl[0] = '{1'b1, A_CTRL,             32'hFFFF_FFFF, A_CTRL,             32'h0000_0001, 1'b1};
    reg_tbl[1] = '{1'b0, 32'h0,              32'h0,         A_CTRL,             32'h0000_0F03, 1'b1};
    reg_tbl[2] = '{1'b1, A_CTRL + 32'd2,     32'h0000_0001, A_DATA + 32'd1,     32'h0000_1234, 1'b1};
    reg_tbl[3] = '{1'b1, A_STAT,             32'hFFFF_FFFF, BASE + 32'd12,      32'h0,         1'b0};
    reg_tbl[4] = '{1'b1, BASE + 32'h10,      32'hDEAD_BEEF, A_CTRL + 32'd3,     32'h0000_0001, 1'b1};
    reg_tbl[5] = '{1'b0, 32'h0,              32'h0,         A_DATA + 32'd3,     32'h0000_1234, 1'b1};
    reg_tbl[6] = '{1'b1, A_DATA,             32'hFFFF_FFFF, 32'h0,              32'h0,         1'b0};
    reg_tbl[7] = '{1'b0, 32'h0,              32'h0,         A_DATA,             32'h0000_FFFF, 1'b1};
    reg_tbl[8] = '{1'b1, A_DATA,             32'h0000_1234, BASE - 32'd4,       32'h0,         1'b0};
    reg_tbl[9] = '{1'b0, 32'h0,              32'h0,         A_DATA,             32'h0000_1234, 1'b1};

    // Reset values on both polarities, then the scan timing from release.
    idle();
    reset = 1'b0;
    #12;
    chk_out("in_reset", 4'b0000, 7'h00);
    check("in_reset rdata", rd_data, 32'h0);
    check("in_reset hit", {31'd0, rd_hit}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    write(A_DATA, 32'h0000_1234);
    for (int i = 0; i < 10; i++) begin
      for (int n = 0; n < int'(scan_tbl[i].cycles); n++) begin
        tick();
        idle();
        chk_out($sformatf("scan%0d.%0d", i, n), scan_tbl[i].sel, scan_tbl[i].seg);
      end
    end

    // Register access vectors.
    for (int i = 0; i < 10; i++) begin
      we    = reg_tbl[i].we;
      waddr = reg_tbl[i].waddr;
      wdata = reg_tbl[i].wdata;
      raddr = reg_tbl[i].raddr;
      tick();
      idle();
      check($sformatf("reg%0d rdata", i), rd_data, reg_tbl[i].exp_data);
      check($sformatf("reg%0d hit", i), {31'd0, rd_hit}, {31'd0, reg_tbl[i].exp_hit});
    end

    // Leading-zero blanking.
    do_reset();
    write(A_CTRL, 32'h0000_0003);
    tick();
    write(A_DATA, 32'h0000_0005);
    tick();
    idle();
    tick();
    observe("lzb_0005", 40, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h6D});
    write(A_DATA, 32'h0000_0105);
    tick();
    idle();
    tick();
    observe("lzb_0105", 40, 4'b0111, {7'h00, 7'h06, 7'h3F, 7'h6D});
    write(A_DATA, 32'h0000_0000);
    tick();
    idle();
    tick();
    observe("lzb_0000", 40, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h3F});

    // Digit mask.
    do_reset();
    write(A_DATA, 32'h0000_1234);
    tick();
    write(A_CTRL, 32'h0000_0401);
    tick();
    idle();
    tick();
    observe("mask2", 40, 4'b1011, {7'h06, 7'h5B, 7'h4F, 7'h66});

    // Enable hold mid-LIT on digit 1 with two prescaler counts left.
    do_reset();
    write(A_DATA, 32'h0000_1234);
    tick();
    idle();
    repeat (5) tick();
    chk_out("en e6", 4'b0010, 7'h4F);
    write(A_CTRL, 32'h0000_0000);
    tick();
    chk_out("en e7", 4'b0010, 7'h4F);
    idle();
    raddr = A_STAT;
    tick();
    chk_out("en off e8", 4'b0000, 7'h00);
    check("en off status e8", rd_data, 32'h0000_0001);
    write(A_STAT, 32'hFFFF_FFFF);
    raddr = A_STAT;
    tick();
    idle();
    raddr = A_STAT;
    check("status write e9", rd_data, 32'h0000_0001);
    for (int e = 10; e <= 12; e++) begin
      tick();
      chk_out($sformatf("en off e%0d", e), 4'b0000, 7'h00);
      check($sformatf("frozen status e%0d", e), rd_data, 32'h0000_0001);
    end
    write(A_CTRL, 32'h0000_0001);
    raddr = A_STAT;
    tick();
    we = 1'b0;
    chk_out("reen e13", 4'b0000, 7'h00);
    tick();
    chk_out("reen e14", 4'b0010, 7'h4F);
    tick();
    chk_out("reen e15", 4'b0010, 7'h4F);
    check("reen status e15", rd_data, 32'h0000_0001);
    tick();
    chk_out("reen gap e16", 4'b0000, 7'h00);
    check("gap status e16", rd_data, 32'h0000_0101);
    tick();
    chk_out("reen e17", 4'b0100, 7'h5B);
    check("status e17", rd_data, 32'h0000_0002);

    // Same-cycle read and write of DATA.
    do_reset();
    write(A_DATA, 32'h0000_1234);
    tick();
    chk_out("rw e1", 4'b0001, 7'h3F);
    write(A_DATA, 32'h0000_ABCD);
    raddr = A_DATA;
    tick();
    idle();
    raddr = A_DATA;
    check("rw old rdata", rd_data, 32'h0000_1234);
    chk_out("rw e2", 4'b0001, 7'h66);
    tick();
    chk_out("rw e3 new nibble", 4'b0001, 7'h5E);
    check("rw new rdata", rd_data, 32'h0000_ABCD);

    // Asynchronous reset during GAP, then restart at digit 0.
    do_reset();
    write(A_DATA, 32'h0000_1234);
    tick();
    idle();
    tick();
    tick();
    raddr = A_DATA;
    tick();
    check("pre_async rdata", rd_data, 32'h0000_1234);
    chk_out("pre_async out", 4'b0001, 7'h66);
    #2;
    reset = 1'b0;
    #1;
    chk_out("async_reset", 4'b0000, 7'h00);
    check("async_reset rdata", rd_data, 32'h0);
    check("async_reset hit", {31'd0, rd_hit}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    raddr = A_STAT;
    tick();
    chk_out("post_reset e1", 4'b0001, 7'h3F);
    check("post_reset status", rd_data, 32'h0);
    check("post_reset hit", {31'd0, rd_hit}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
